add_sub_norm_round: RTL and testbench
=====================================

Name: add_sub_norm_round

Overview:
Post-alignment back end of the FPU add/sub datapath. It accepts the raw mantissa sum/difference, the larger-operand exponent and the result sign, then normalises, rounds to nearest-even and packs an IEEE-754 word. It is a 2-stage valid/ready pipeline that sits between the mantissa adder and the FFT butterfly result registers.

Parameters:
EXP_W, 8, exponent width
MAN_W, 23, stored fraction width
SUM_W, MAN_W+5, raw sum width: [SUM_W-1] carry, [SUM_W-2] hidden, fraction, then G, R, S

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream item present
o_ready  output  1  block can accept an item this cycle
i_sign  input  1  result sign
i_exp  input  EXP_W  exponent of the greater operand
i_mant  input  SUM_W  unnormalised mantissa sum with G/R/S
o_valid  output  1  result present
i_ready  input  1  downstream accepts
o_data  output  1+EXP_W+MAN_W  packed result {sign, exp, frac}
o_overflow  output  1  result saturated to infinity
o_underflow  output  1  result flushed to zero

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. On reset, both stage valid flags, o_valid, o_data, o_overflow and o_underflow clear to 0.
- Reset mid-operation: all in-flight items are discarded. o_ready is 1 in the first cycle after release.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - Stage k loads when it is empty or stage k+1 loads or drains in the same cycle.
  - o_ready = !s1_valid || s1_advance.
  - Output data and flags hold stable while o_valid && !i_ready.
  - Full throughput is 1 item/cycle. No drops, no duplicates, order is preserved.
- Latency: 2 cycles, input accept to o_valid, when no stall.
- Stage 1 (normalise):
  - Carry set: shift right by 1, OR the shifted-out bit into S, exp+1.
  - Carry clear, mant != 0: lz = leading zeros counted from the hidden bit. Shift left by lz with zero fill; exp_n = exp - lz computed signed, width EXP_W+2.
  - mant == 0 (exact cancellation): result +0, flags 0.
  - i_exp all-ones (Inf/NaN): bypass. Output is Inf with i_sign if the fraction is 0, else canonical qNaN 0x7FC00000. Flags 0.
- Stage 2 (round and pack):
  - round_up = G & (R | S | frac_lsb).
  - frac + round_up carrying out of MAN_W bits: frac=0, exp_n+1.
  - exp_n >= 2^EXP_W-1: output {sign, all-ones, 0}, o_overflow=1.
  - exp_n <= 0: output {sign, 0, 0}, o_underflow=1. Denormals are flushed; rounding is not applied.
  - Otherwise pack {sign, exp_n[EXP_W-1:0], frac}.
- Flags are per-item and travel with the data.
- Simultaneous accept and drain while full: allowed, with no bubble inserted.

Decomposition:
- Package fpu_pkg:
  - EXP_W, MAN_W, SUM_W, BIAS=127, EXP_MAX = all-ones.
  - QNAN constant 0x7FC00000.
  - Packed struct for the stage-1 to stage-2 payload: sign, signed exp, normalised mantissa with G/R/S, zero/special/nan bits.
- Sub-module add_sub_lzc: combinational leading-zero counter over SUM_W-1 bits. Output width $clog2(SUM_W). Output SUM_W-1 when the input is all zero.

Test Plan:
- 1.0+1.0: i_sign=0, i_exp=127, i_mant=0x8000000 (carry only) -> o_data=0x40000000, flags 0, o_valid exactly 2 cycles after accept.
- Cancellation and left shift:
  - i_exp=127, i_mant=0 -> 0x00000000.
  - i_exp=127, i_mant=0x1000000 (lz=2) -> 0x3E800000.
- RNE ties, i_exp=127:
  - i_mant=0x0400000C (lsb=1, G=1) -> 0x3F800002.
  - i_mant=0x04000004 (lsb=0, G=1) -> 0x3F800000.
- Range limits:
  - i_exp=254, i_mant=0x8000000 -> 0x7F800000, o_overflow=1.
  - i_sign=1, i_exp=1, i_mant=0x2000000 -> 0x80000000, o_underflow=1.
  - i_exp=255 with fraction bits nonzero -> 0x7FC00000.
- Backpressure: stream 5 back-to-back items, hold i_ready=0 for 3 cycles after the first o_valid -> o_ready drops once both stages are full, o_data holds stable, all 5 results emerge in order with no gaps after i_ready=1.
- Reset mid-stream: drop i_rst_n asynchronously with both stages full -> o_valid=0 immediately, no stale item appears after release, the next accepted item returns correctly 2 cycles later.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_pkg
//  Purpose  : Shared widths, constants and the stage-1 -> stage-2 payload
//             type for the add/sub normalise-and-round back end.
//  Revision : 1.0  initial release
// ============================================================================
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    // Raw sum layout: [SUM_W-1] carry, [SUM_W-2] hidden, fraction, G, R, S
    localparam int SUM_W = MAN_W + 5;
    localparam int BIAS  = 127;

    localparam logic [EXP_W-1:0]         EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W+MAN_W:0]     QNAN    = 32'h7FC0_0000;

    // The hidden bit is implied once normalised, so only fraction + G/R/S
    // are carried into the rounding stage.
    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W+1:0] exp;
        logic [SUM_W-3:0]        mant;
        logic                    zero;
        logic                    special;
        logic                    nan;
    } s1_payload_t;

endpackage
`default_nettype wire

// File: rtl/add_sub_lzc.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_lzc
//  Purpose  : Combinational leading-zero counter over the hidden bit and
//             everything below it. Returns W-1 for an all-zero input.
//  Ports    : i_vec  [W-2:0]          vector to scan (MSB = hidden bit)
//             o_cnt  [$clog2(W)-1:0]  leading zero count
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_lzc
    import fpu_pkg::*;
#(
    parameter int W = SUM_W
) (
    input  logic [W-2:0]           i_vec,
    output logic [$clog2(W)-1:0]   o_cnt
);

    localparam int CNT_W = $clog2(W);

    logic w_found;

    // Priority scan from the MSB; first set bit wins.
    always_comb begin
        o_cnt   = CNT_W'(W - 1);
        w_found = 1'b0;
        for (int i = W - 2; i >= 0; i--) begin
            if (!w_found && i_vec[i]) begin
                o_cnt   = CNT_W'(W - 2 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_sub_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_norm_round
//  Purpose  : Normalise, round-to-nearest-even and pack the raw mantissa
//             sum of the FPU add/sub datapath. Two-stage valid/ready pipe.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_valid/o_ready  upstream handshake; i_sign, i_exp, i_mant
//             o_valid/i_ready  downstream handshake; o_data {sign,exp,frac}
//             o_overflow (saturated to Inf), o_underflow (flushed to zero)
//  Revision : 1.0  initial release
// ============================================================================
module add_sub_norm_round #(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W,
    parameter int SUM_W = fpu_pkg::SUM_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_sign,
    input  logic [EXP_W-1:0]       i_exp,
    input  logic [SUM_W-1:0]       i_mant,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [EXP_W+MAN_W:0]   o_data,
    output logic                   o_overflow,
    output logic                   o_underflow
);
    import fpu_pkg::*;

    localparam int LZ_W = $clog2(SUM_W);
    localparam int EW   = EXP_W + 2;

    // ------------------------------------------------------------------
    // Stage 1: normalise
    // ------------------------------------------------------------------
    logic                 w_carry;
    logic [SUM_W-2:0]     w_low;
    logic [LZ_W-1:0]      w_lz;
    logic [SUM_W-3:0]     w_shl;
    logic [EW-1:0]        w_exp_ext;
    s1_payload_t          s1_d;
    s1_payload_t          s1_q;
    logic                 s1_valid_q;

    assign w_carry   = i_mant[SUM_W-1];
    assign w_low     = i_mant[SUM_W-2:0];
    assign w_exp_ext = {2'b00, i_exp};
    // The hidden bit lands just above this window after the shift and is
    // dropped, so only the bits below it need shifting.
    assign w_shl     = w_low[SUM_W-3:0] << w_lz;

    add_sub_lzc #(.W(SUM_W)) u_lzc (
        .i_vec (w_low),
        .o_cnt (w_lz)
    );

    always_comb begin
        s1_d      = '0;
        s1_d.sign = i_sign;
        if (&i_exp) begin
            s1_d.special = 1'b1;
            s1_d.nan     = |i_mant[SUM_W-3:3];
        end else if (w_carry) begin
            // Right shift by one; bits falling off the end fold into sticky.
            s1_d.exp  = w_exp_ext + EW'(1);
            s1_d.mant = {i_mant[SUM_W-2:2], |i_mant[1:0]};
        end else if (w_low == '0) begin
            s1_d.sign = 1'b0;
            s1_d.zero = 1'b1;
        end else begin
            s1_d.exp  = w_exp_ext - {{(EW-LZ_W){1'b0}}, w_lz};
            s1_d.mant = w_shl;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round and pack (combinational from the stage-1 register)
    // ------------------------------------------------------------------
    logic                  w_round_up;
    logic [MAN_W:0]        w_rnd;
    logic [EW-1:0]         w_exp_r;
    logic                  w_unf;
    logic                  w_ovf;
    logic [EXP_W+MAN_W:0]  s2_data_d;
    logic                  s2_ovf_d;
    logic                  s2_unf_d;

    assign w_round_up = s1_q.mant[2] & (s1_q.mant[1] | s1_q.mant[0] | s1_q.mant[3]);
    assign w_rnd      = {1'b0, s1_q.mant[SUM_W-3:3]} + {{MAN_W{1'b0}}, w_round_up};
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign w_exp_r    = s1_q.exp + {{(EW-1){1'b0}}, w_rnd[MAN_W]};
    // Flush decision uses the pre-rounding exponent: denormals never round.
    assign w_unf      = s1_q.exp[EW-1] | (s1_q.exp == '0);
    // Exponent is non-negative here and never exceeds 2^EXP_W+1.
    assign w_ovf      = !w_exp_r[EW-1] & (w_exp_r[EW-2] | (&w_exp_r[EXP_W-1:0]));

    always_comb begin
        s2_data_d = '0;
        s2_ovf_d  = 1'b0;
        s2_unf_d  = 1'b0;
        if (s1_q.special) begin
            s2_data_d = s1_q.nan ? QNAN : {s1_q.sign, EXP_MAX, {MAN_W{1'b0}}};
        end else if (s1_q.zero) begin
            s2_data_d = '0;
        end else if (w_unf) begin
            s2_data_d = {s1_q.sign, {(EXP_W+MAN_W){1'b0}}};
            s2_unf_d  = 1'b1;
        end else if (w_ovf) begin
            s2_data_d = {s1_q.sign, EXP_MAX, {MAN_W{1'b0}}};
            s2_ovf_d  = 1'b1;
        end else begin
            s2_data_d = {s1_q.sign, w_exp_r[EXP_W-1:0], w_rnd[MAN_W-1:0]};
        end
    end

    // ------------------------------------------------------------------
    // Handshake and pipeline registers
    // ------------------------------------------------------------------
    logic w_s2_free;
    logic w_s1_advance;
    logic o_valid_q;
    logic [EXP_W+MAN_W:0] o_data_q;
    logic o_overflow_q;
    logic o_underflow_q;

    assign w_s2_free    = !o_valid_q || i_ready;
    assign w_s1_advance = s1_valid_q && w_s2_free;
    assign o_ready      = !s1_valid_q || w_s1_advance;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (o_ready) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_overflow_q  <= 1'b0;
            o_underflow_q <= 1'b0;
        end else if (w_s2_free) begin
            o_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                o_data_q      <= s2_data_d;
                o_overflow_q  <= s2_ovf_d;
                o_underflow_q <= s2_unf_d;
            end
        end
    end

    assign o_valid     = o_valid_q;
    assign o_data      = o_data_q;
    assign o_overflow  = o_overflow_q;
    assign o_underflow = o_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_norm_round.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_norm_round
//  Purpose  : Directed-vector scoreboard bench for add_sub_norm_round.
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_sub_norm_round;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign = 1'b0;
    logic [7:0]  i_exp = '0;
    logic [27:0] i_mant = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_data;
    logic        o_overflow;
    logic        o_underflow;

    add_sub_norm_round dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        ovf;
        logic        unf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input string nm, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [31:0] d,
                        input logic ov, input logic un, input bit lat);
        bit done = 0;
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = e;
        i_mant  = m;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                sb.push_back('{nm, d, ov, un, cyc, lat});
                done = 1;
            end
            @(posedge i_clk);
            #1;
        end
        if (!done) fail_now({nm, "_accept"});
        i_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge i_clk);
        if (sb.size() != 0) fail_now({nm, "_drain"});
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: compares the head of the scoreboard every cycle an output is
    // presented; pops only when the downstream accepts it.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid) begin
            if (sb.size() == 0) begin
                if (i_ready) chk("unexpected_output", {31'b0, o_valid}, 64'd0);
            end else begin
                chk(sb[0].name, {30'b0, o_data, o_overflow, o_underflow},
                    {30'b0, sb[0].data, sb[0].ovf, sb[0].unf});
                if (i_ready) begin
                    if (sb[0].lat) chk({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc), 64'd2);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_o_valid", {63'b0, o_valid}, 64'd0);
        chk("rst_o_data", {32'b0, o_data}, 64'd0);
        chk("rst_flags", {62'b0, o_overflow, o_underflow}, 64'd0);
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_o_ready", {63'b0, o_ready}, 64'd1);
        @(posedge i_clk);
        #1;

        // Directed vectors
        send("one_plus_one", 0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 1);
        drain("one_plus_one");
        send("cancel",     0, 8'd127, 28'h0000000, 32'h00000000, 0, 0, 0);
        send("lshift2",    0, 8'd127, 28'h1000000, 32'h3E800000, 0, 0, 0);
        send("rne_tie_up", 0, 8'd127, 28'h400000C, 32'h3F800002, 0, 0, 0);
        send("rne_tie_ev", 0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 0);
        send("overflow",   0, 8'd254, 28'h8000000, 32'h7F800000, 1, 0, 0);
        send("underflow",  1, 8'd1,   28'h2000000, 32'h80000000, 0, 1, 0);
        send("qnan",       0, 8'd255, 28'h0000008, 32'h7FC00000, 0, 0, 0);
        send("neg_inf",    1, 8'd255, 28'h0000000, 32'hFF800000, 0, 0, 0);
        send("neg_1p5",    1, 8'd130, 28'h6000000, 32'hC1400000, 0, 0, 0);
        send("rnd_carry",  0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 0);
        send("carry_rne",  0, 8'd127, 28'h8000018, 32'h40000002, 0, 0, 0);
        drain("vectors");

        // Backpressure: five back-to-back items, downstream stalled
        i_ready = 1'b0;
        fork
            begin
                send("bp0", 0, 8'd120, 28'h4000000, 32'h3C000000, 0, 0, 0);
                send("bp1", 0, 8'd121, 28'h4000000, 32'h3C800000, 0, 0, 0);
                send("bp2", 0, 8'd122, 28'h4000000, 32'h3D000000, 0, 0, 0);
                send("bp3", 0, 8'd123, 28'h4000000, 32'h3D800000, 0, 0, 0);
                send("bp4", 0, 8'd124, 28'h4000000, 32'h3E000000, 0, 0, 0);
            end
            begin
                bit seen = 0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge i_clk);
                    seen = o_valid;
                end
                if (!seen) fail_now("bp_first_valid");
                chk("bp_ready_low", {63'b0, o_ready}, 64'd0);
                @(negedge i_clk);
                @(negedge i_clk);
                chk("bp_ready_still_low", {63'b0, o_ready}, 64'd0);
                @(posedge i_clk);
                #1 i_ready = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge i_clk);
                    chk("bp_no_gap", {63'b0, o_valid}, 64'd1);
                end
            end
        join
        drain("backpressure");

        // Reset with both stages full
        i_ready = 1'b0;
        send("rst_x", 0, 8'd100, 28'h4000000, 32'h32000000, 0, 0, 0);
        send("rst_y", 0, 8'd101, 28'h4000000, 32'h32800000, 0, 0, 0);
        @(negedge i_clk);
        chk("mid_full_valid", {63'b0, o_valid}, 64'd1);
        chk("mid_full_ready", {63'b0, o_ready}, 64'd0);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, o_valid}, 64'd0);
        sb.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("post_rst_ready", {63'b0, o_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_no_stale", {63'b0, o_valid}, 64'd0);
            @(negedge i_clk);
        end
        @(posedge i_clk);
        #1;
        send("post_rst_item", 1, 8'd127, 28'h8000000, 32'hC0000000, 0, 0, 1);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
